adder_rr_sched: RTL

- Round-robin scheduler that shares one pipelined W-bit adder among N_REQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and issues at most one operation per cycle to the adder.
- Issue timing: operand A and start go out in the issue cycle; operand B goes out one cycle later.
- Tags each in-flight operation with its requester ID and returns the sum with that ID.
- Supports a controlled drain/halt for reconfiguration or power-down.

---
 rtl/adder_sched_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/adder_rr_sched.sv | 131 +++++++++++++
 3 files changed

// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg: shared state, tag and latency definitions for adder_rr_sched
package adder_sched_pkg;

    localparam int MAX_IDW = 4;
    localparam int ADD_LAT = 2;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALT
    } sched_state_e;

    typedef struct packed {
        logic               vld;
        logic [MAX_IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, searching upward from ptr with wrap
module rr_arbiter #(
    parameter int  N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           en,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] idx
);

    logic [IDW-1:0] cand;
    logic           found;

    // first pending requester at or after ptr wins; N-1 wraps back to 0
    always_comb begin
        gnt   = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = IDW'((int'(ptr) + k) % N);
            if (en && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/adder_rr_sched.sv
// adder_rr_sched: round-robin sharing of one pipelined adder among N_REQ requesters.
// Defining ADDER_RR_SCHED_PERF_EN adds per-requester grant counters and an adder busy counter.
module adder_rr_sched
    import adder_sched_pkg::*;
#(
    parameter int  W     = 20,
    parameter int  N_REQ = 4,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic               add_start,
    output logic [W-1:0]       add_a,
    output logic [W-1:0]       add_b,
    input  logic [W-1:0]       add_y,
    input  logic               add_valid,
    output logic               resp_valid,
    output logic [IDW-1:0]     resp_id,
    output logic [W-1:0]       resp_y,
    input  logic               halt_req,
    output logic               halted,
    output logic               tag_err
`ifdef ADDER_RR_SCHED_PERF_EN
    ,
    output logic [N_REQ*16-1:0] grant_cnt,
    output logic [31:0]         busy_cnt
`endif
);

    sched_state_e     state;
    logic [IDW-1:0]   rr_ptr;
    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_idx;
    logic             xfer;
    logic [W-1:0]     b_q;
    tag_t             tag_q [ADD_LAT];
    logic             pipe_clear;
    logic             unused_tag_id;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .en  (state == RUN && !halt_req),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign req_ready     = gnt;
    assign xfer          = |gnt;
    assign add_start     = xfer;
    assign add_a         = xfer ? req_a[int'(gnt_idx)*W +: W] : '0;
    assign add_b         = b_q;
    assign resp_valid    = add_valid;
    assign resp_y        = add_y;
    assign resp_id       = tag_q[ADD_LAT-1].id[IDW-1:0];
    assign unused_tag_id = ^tag_q[ADD_LAT-1].id;

    // pipeline is empty after this edge when no stage ahead of the tail holds a tag
    always_comb begin
        pipe_clear = 1'b1;
        for (int k = 0; k < ADD_LAT-1; k++) pipe_clear = pipe_clear & !tag_q[k].vld;
    end

    // capture operand B and the owner tag on transfer, age tags toward the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            b_q    <= '0;
            for (int k = 0; k < ADD_LAT; k++) tag_q[k] <= '0;
        end else begin
            tag_q[0] <= tag_t'{vld: xfer, id: MAX_IDW'(gnt_idx)};
            for (int k = 1; k < ADD_LAT; k++) tag_q[k] <= tag_q[k-1];
            if (xfer) begin
                b_q    <= req_b[int'(gnt_idx)*W +: W];
                rr_ptr <= (int'(gnt_idx) == N_REQ-1) ? '0 : gnt_idx + IDW'(1);
            end
        end
    end

    // RUN/DRAIN/HALT sequencing with halted registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            halted <= 1'b0;
        end else begin
            case (state)
                RUN: if (halt_req) state <= DRAIN;
                DRAIN: begin
                    if (!halt_req) state <= RUN;
                    else if (pipe_clear) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end
                end
                HALT: begin
                    if (!halt_req) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // any disagreement between adder valid and the tail tag is latched until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tag_err <= 1'b0;
        else if (add_valid != tag_q[ADD_LAT-1].vld) tag_err <= 1'b1;
    end

`ifdef ADDER_RR_SCHED_PERF_EN
    // per-requester saturating transfer counts and a wrapping count of issue cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
            busy_cnt  <= '0;
        end else begin
            if (add_start) busy_cnt <= busy_cnt + 32'd1;
            for (int i = 0; i < N_REQ; i++)
                if (gnt[i] && grant_cnt[i*16 +: 16] != 16'hFFFF)
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
        end
    end
`endif

endmodule
